// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low pattern table (bit0=a .. bit6=g),
// qualifier states and the decimal successor used by the sequence checker.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Indexed by the decimal value so the encoder and decoder share one table.
  localparam logic [6:0] SEG_TAB [10] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
  };

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] value;
    logic       is_digit;
    logic       is_blank;
  } seg_dec_t;

  function automatic logic [3:0] next_dec(input logic [3:0] v);
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational pattern classifier: recovers the decimal value of a legal
// active-low segment pattern and flags blank; anything else is neither.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);

  logic [9:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_match
      assign hit[gi] = (seg_i == SEG_TAB[gi]);
    end
  endgenerate

  always_comb begin
    dec_o          = '0;
    dec_o.is_blank = (seg_i == SEG_BLANK);
    for (int i = 0; i < 10; i++) begin
      if (hit[i]) begin
        dec_o.value    = 4'(i);
        dec_o.is_digit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_decode_monitor.sv
// On-chip checker for a HEX digit driver: qualifies stable segment patterns,
// decodes them, checks +1 mod 10 progression and keeps saturating tallies.
module seg7_decode_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             sample_en,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             invalid,
  output logic             seq_err,
  output logic [CNT_W-1:0] accept_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]       STABLE_LIM = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [6:0]       seg_q, seg_d;
  logic [6:0]       cand_q, cand_d;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  logic             sampled_q, sampled_d;
  logic [6:0]       acc_pat_q, acc_pat_d;
  logic             acc_vld_q, acc_vld_d;
  logic [3:0]       prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, digit_valid_d;
  logic             invalid_q, invalid_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] accept_count_q, accept_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             load, done;
  seg_dec_t         dec;

  // Every accept decision concerns the pattern currently held in seg_q.
  seg7_to_bcd u_dec (
    .seg_i (seg_q),
    .dec_o (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WAIT;
      seg_q          <= '0;
      cand_q         <= '0;
      stab_cnt_q     <= '0;
      sampled_q      <= 1'b0;
      acc_pat_q      <= '0;
      acc_vld_q      <= 1'b0;
      prev_q         <= '0;
      have_prev_q    <= 1'b0;
      digit_q        <= '0;
      digit_valid_q  <= 1'b0;
      invalid_q      <= 1'b0;
      seq_err_q      <= 1'b0;
      accept_count_q <= '0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      seg_q          <= seg_d;
      cand_q         <= cand_d;
      stab_cnt_q     <= stab_cnt_d;
      sampled_q      <= sampled_d;
      acc_pat_q      <= acc_pat_d;
      acc_vld_q      <= acc_vld_d;
      prev_q         <= prev_d;
      have_prev_q    <= have_prev_d;
      digit_q        <= digit_d;
      digit_valid_q  <= digit_valid_d;
      invalid_q      <= invalid_d;
      seq_err_q      <= seq_err_d;
      accept_count_q <= accept_count_d;
      err_count_q    <= err_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    seg_d          = seg_q;
    cand_d         = cand_q;
    stab_cnt_d     = stab_cnt_q;
    sampled_d      = sampled_q;
    acc_pat_d      = acc_pat_q;
    acc_vld_d      = acc_vld_q;
    prev_d         = prev_q;
    have_prev_d    = have_prev_q;
    digit_d        = digit_q;
    digit_valid_d  = 1'b0;
    invalid_d      = 1'b0;
    seq_err_d      = 1'b0;
    accept_count_d = accept_count_q;
    err_count_d    = err_count_q;
    load           = 1'b0;
    done           = 1'b0;

    if (sample_en) begin
      seg_d     = seg_in;
      sampled_d = 1'b1;
      // In WAIT, seg_q still holds its reset value until the first real sample lands.
      if (state_q == WAIT) begin
        load = sampled_q;
      end else if (seg_q != cand_q) begin
        load = 1'b1;
      end else if (state_q == QUAL) begin
        stab_cnt_d = stab_cnt_q + 8'd1;
        if (stab_cnt_d == STABLE_LIM) begin
          done    = 1'b1;
          state_d = HOLD;
        end
      end

      if (load) begin
        cand_d     = seg_q;
        stab_cnt_d = 8'd1;
        state_d    = QUAL;
        if (STABLE_LIM == 8'd1) begin
          done    = 1'b1;
          state_d = HOLD;
        end
      end
    end

    // A pattern that returns after a short glitch is not reported a second time.
    if (done && !(acc_vld_q && (seg_q == acc_pat_q))) begin
      acc_pat_d = seg_q;
      acc_vld_d = 1'b1;
      if (dec.is_digit) begin
        digit_d       = dec.value;
        digit_valid_d = 1'b1;
        if (accept_count_q != CNT_MAX) accept_count_d = accept_count_q + 1'b1;
        if (have_prev_q && (dec.value != next_dec(prev_q))) begin
          seq_err_d = 1'b1;
          if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
        end
        prev_d      = dec.value;
        have_prev_d = 1'b1;
      end else if (!dec.is_blank) begin
        invalid_d   = 1'b1;
        have_prev_d = 1'b0;
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
      end
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = digit_valid_q;
  assign invalid      = invalid_q;
  assign seq_err      = seq_err_q;
  assign accept_count = accept_count_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Bench for seg7_decode_monitor: directed scenarios plus random traffic, all
// checked every cycle against a run-length model of the accept rules.
module tb_seg7_decode_monitor;

  localparam int STABLE = 4;
  localparam int CW     = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    seg_in;
  logic          sample_en;
  logic [3:0]    digit;
  logic          digit_valid, invalid, seq_err;
  logic [CW-1:0] accept_count, err_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_decode_monitor #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .sample_en    (sample_en),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .invalid      (invalid),
    .seq_err      (seq_err),
    .accept_count (accept_count),
    .err_count    (err_count)
  );

  // Index 0..9 are digits, 10 is blank.
  logic [6:0] tab [0:10];

  int         m_run_len;
  logic [6:0] m_run_pat;
  bit         m_last_vld;
  logic [6:0] m_last_pat;
  int         m_digit, m_prev, m_acc, m_err;
  bit         m_have_prev;
  bit         e_dv, e_inv, e_seq;

  function automatic int classify(input logic [6:0] p);
    for (int i = 0; i < 11; i++) if (tab[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  // A pattern is accepted on the enabled edge after its run of identical
  // enabled samples reaches STABLE, unless it repeats the last accepted pattern.
  task automatic model_edge(input logic [6:0] s, input logic en, input logic rst);
    int c;
    e_dv = 0; e_inv = 0; e_seq = 0;
    if (rst) begin
      m_run_len = 0; m_run_pat = '0; m_last_vld = 0; m_last_pat = '0;
      m_digit = 0; m_prev = 0; m_have_prev = 0; m_acc = 0; m_err = 0;
    end else if (en) begin
      if (m_run_len == STABLE && !(m_last_vld && m_last_pat == m_run_pat)) begin
        m_last_vld = 1; m_last_pat = m_run_pat;
        c = classify(m_run_pat);
        if (c < 0) begin
          e_inv = 1; m_have_prev = 0;
          if (m_err < 65535) m_err++;
        end else if (c < 10) begin
          e_dv = 1; m_digit = c;
          if (m_acc < 65535) m_acc++;
          if (m_have_prev && c != (m_prev + 1) % 10) begin
            e_seq = 1;
            if (m_err < 65535) m_err++;
          end
          m_prev = c; m_have_prev = 1;
        end
      end
      if (m_run_len > 0 && s == m_run_pat) m_run_len++;
      else begin m_run_pat = s; m_run_len = 1; end
    end
  endtask

  task automatic step(input logic [6:0] s, input logic en, input logic rst);
    seg_in = s; sample_en = en; reset = rst;
    @(posedge clk);
    model_edge(s, en, rst);
    #1;
    chk("digit", 32'(digit), 32'(m_digit));
    chk("digit_valid", 32'(digit_valid), 32'(e_dv));
    chk("invalid", 32'(invalid), 32'(e_inv));
    chk("seq_err", 32'(seq_err), 32'(e_seq));
    chk("accept_count", 32'(accept_count), 32'(m_acc));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic hold(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    step(7'h7F, 1'b1, 1'b1);
    step(7'h7F, 1'b1, 1'b1);
  endtask

  initial begin
    int idx;
    logic [6:0] p;
    tab[0] = 7'b1000000; tab[1] = 7'b1111001; tab[2] = 7'b0100100;
    tab[3] = 7'b0110000; tab[4] = 7'b0011001; tab[5] = 7'b0010010;
    tab[6] = 7'b0000010; tab[7] = 7'b1111000; tab[8] = 7'b0000000;
    tab[9] = 7'b0010000; tab[10] = 7'b1111111;
    seg_in = '0; sample_en = 1'b0; reset = 1'b1;

    // Reset state, then a held "1": one pulse on the fifth edge, none after.
    do_reset();
    idx = -1;
    for (int i = 0; i < 12; i++) begin
      step(tab[1], 1'b1, 1'b0);
      if (digit_valid && idx < 0) idx = i;
    end
    chk("hold_latency", 32'(idx), 32'd4);
    chk("hold_accept", 32'(accept_count), 32'd1);

    // Counting 0..9,0 with the 9->0 wrap.
    do_reset();
    for (int d = 0; d < 11; d++) hold(tab[d % 10], 6);
    chk("count_accept", 32'(accept_count), 32'd11);
    chk("count_err", 32'(err_count), 32'd0);

    // 3 then 5 is a sequence error.
    do_reset();
    hold(tab[3], 6);
    hold(tab[5], 6);
    chk("skip_digit", 32'(digit), 32'd5);
    chk("skip_err", 32'(err_count), 32'd1);

    // Two-sample glitch inside a stable 2.
    do_reset();
    hold(tab[2], 6);
    hold(7'b0000001, 2);
    hold(tab[2], 6);
    chk("glitch_accept", 32'(accept_count), 32'd1);
    chk("glitch_err", 32'(err_count), 32'd0);

    // Illegal pattern clears the sequence history; blank preserves it.
    do_reset();
    hold(7'b0101010, 6);
    hold(tab[7], 6);
    hold(tab[8], 6);
    hold(tab[10], 6);
    hold(tab[9], 6);
    chk("illegal_accept", 32'(accept_count), 32'd3);
    chk("illegal_err", 32'(err_count), 32'd1);

    // Reset two samples into a new pattern, then gate sample_en mid-qualification.
    do_reset();
    hold(tab[4], 2);
    do_reset();
    idx = -1;
    for (int i = 0; i < 30; i++) begin
      step(tab[6], !(i >= 2 && i < 12), 1'b0);
      if (digit_valid && idx < 0) idx = i;
    end
    chk("gated_latency", 32'(idx), 32'd14);

    // Random traffic: legal, blank and arbitrary patterns with gaps and resets.
    for (int n = 0; n < 250; n++) begin
      idx = int'($urandom_range(0, 11));
      if (idx == 11) p = 7'($urandom_range(0, 127));
      else           p = tab[idx];
      for (int k = 0; k < int'($urandom_range(1, 7)); k++)
        step(p, $urandom_range(0, 9) != 0, $urandom_range(0, 149) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
